// File: rtl/cacheline_adaptor.sv
// Bridges a whole-cacheline read/write request from the cache to a
// fixed-length burst of memory beats, assembling or slicing the line as it goes.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic [31:0]        address_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beats = s_line / s_burst;
  localparam logic [31:0] offset_mask = 32'(s_line / 8 - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [1:0]        count;
  logic [1:0]        next_count;
  logic [s_line-1:0] line_q;
  logic              last_beat;

  assign next_count = count + 2'd1;
  assign last_beat  = (count == 2'(beats - 1));

  // The write line is captured at acceptance so the cache may change line_i
  // while the burst is in flight; burst_o is pre-loaded one beat ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= 2'd0;
      line_q    <= '0;
      line_o    <= '0;
      address_o <= '0;
      burst_o   <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          count <= 2'd0;
          if (read_i) begin
            state     <= READ;
            read_o    <= 1'b1;
            address_o <= address_i & ~offset_mask;
          end else if (write_i) begin
            state     <= WRITE;
            write_o   <= 1'b1;
            address_o <= address_i & ~offset_mask;
            line_q    <= line_i;
            burst_o   <= line_i[s_burst-1:0];
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[s_burst*int'(count) +: s_burst] <= burst_i;
            count <= next_count;
            if (last_beat) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            count   <= next_count;
            burst_o <= line_q[s_burst*int'(next_count) +: s_burst];
            if (last_beat) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model is checked
// against the DUT every cycle, plus literal expectations for each scenario.
module tb_cacheline_adaptor;

  localparam int s_line  = 256;
  localparam int s_burst = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        address_i = '0;
  logic [s_line-1:0]  line_i = '0;
  logic [s_line-1:0]  line_o;
  logic               read_i = 1'b0;
  logic               write_i = 1'b0;
  logic               resp_o;
  logic [31:0]        address_o;
  logic [s_burst-1:0] burst_i = '0;
  logic [s_burst-1:0] burst_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i = 1'b0;

  cacheline_adaptor #(.s_line(s_line), .s_burst(s_burst)) dut (
    .clk(clk), .rst(rst), .address_i(address_i), .line_i(line_i), .line_o(line_o),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .address_o(address_o),
    .burst_i(burst_i), .burst_o(burst_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  bit checking = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: a burst is just "beats still owed" plus a pending completion.
  int               m_kind = 0;
  int               m_left = 0;
  bit               m_resp = 1'b0;
  logic [31:0]      m_addr = '0;
  logic [s_line-1:0] m_wline = '0;
  logic [s_line-1:0] m_rline = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind = 0; m_left = 0; m_resp = 1'b0; m_addr = '0; m_rline = '0;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_left > 0) begin
      if (resp_i) begin
        if (m_kind == 1) m_rline[s_burst*(4-m_left) +: s_burst] = burst_i;
        m_left--;
        if (m_left == 0) m_resp = 1'b1;
      end
    end else if (read_i) begin
      m_kind = 1; m_left = 4; m_addr = (address_i / 32) * 32;
    end else if (write_i) begin
      m_kind = 2; m_left = 4; m_addr = (address_i / 32) * 32; m_wline = line_i;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check_output("read_o", read_o, m_kind == 1 && m_left > 0);
      check_output("write_o", write_o, m_kind == 2 && m_left > 0);
      check_output("resp_o", resp_o, m_resp);
      check_output("line_o", line_o, m_rline);
      if (m_left > 0) check_output("address_o", address_o, m_addr);
      if (m_kind == 2 && m_left > 0)
        check_output("burst_o", burst_o, m_wline[s_burst*(4-m_left) +: s_burst]);
    end
  end

  task automatic run_read(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3, input int stall_at,
                          input int stall_len, input bit also_write, output int lat,
                          output logic first_rd, output logic [31:0] first_addr, output bit wr_seen);
    logic [63:0] beats [4];
    int k, stalled, acc;
    beats = '{b0, b1, b2, b3};
    @(negedge clk);
    read_i = 1'b1; write_i = also_write; address_i = addr; resp_i = 1'b0;
    line_i = {4{64'hDEAD_BEEF_0BAD_F00D}};
    @(posedge clk);
    #1 acc = edge_cnt;
    address_i = ~addr;
    k = 0; stalled = 0; lat = -1; wr_seen = 1'b0; first_rd = 1'b0; first_addr = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin first_rd = read_o; first_addr = address_o; end
      if (write_o) wr_seen = 1'b1;
      if (resp_o) begin lat = edge_cnt + 1 - acc; break; end
      if (k == stall_at && stalled < stall_len) begin resp_i = 1'b0; stalled++; end
      else if (k < 4) begin resp_i = 1'b1; burst_i = beats[k]; k++; end
      else resp_i = 1'b0;
    end
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    if (lat < 0) check_output("read_timeout", 1'b1, 1'b0);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [s_line-1:0] line,
                           input int reset_after, output logic [63:0] seen [4], output int lat,
                           output logic [31:0] first_addr);
    int k, acc;
    @(negedge clk);
    write_i = 1'b1; address_i = addr; line_i = line; resp_i = 1'b0;
    @(posedge clk);
    #1 acc = edge_cnt;
    address_i = ~addr; line_i = ~line;
    k = 0; lat = -1; first_addr = '0;
    seen = '{default: '0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) first_addr = address_o;
      if (resp_o) begin lat = edge_cnt + 1 - acc; break; end
      if (k == reset_after) begin
        resp_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_output("rst_read_o", read_o, 1'b0);
        check_output("rst_write_o", write_o, 1'b0);
        check_output("rst_resp_o", resp_o, 1'b0);
        check_output("rst_address_o", address_o, 32'h0);
        check_output("rst_burst_o", burst_o, 64'h0);
        check_output("rst_line_o", line_o, '0);
        break;
      end
      if (k < 4) begin resp_i = 1'b1; seen[k] = burst_o; k++; end
      else resp_i = 1'b0;
    end
    write_i = 1'b0; resp_i = 1'b0;
    if (lat < 0 && reset_after < 0) check_output("write_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] b11, b22, b33, b44, wa, wb, wc, wd;
    logic [63:0] seen [4];
    logic [255:0] rd_line;
    logic first_rd;
    logic [31:0] first_addr;
    bit wr_seen;
    int lat;

    b11 = 64'h1111_1111_1111_1111; b22 = 64'h2222_2222_2222_2222;
    b33 = 64'h3333_3333_3333_3333; b44 = 64'h4444_4444_4444_4444;
    wa = 64'hAAAA_0000_AAAA_0001; wb = 64'hBBBB_0000_BBBB_0002;
    wc = 64'hCCCC_0000_CCCC_0003; wd = 64'hDDDD_0000_DDDD_0004;
    rd_line = {b44, b33, b22, b11};

    repeat (3) @(negedge clk);
    check_output("reset_read_o", read_o, 1'b0);
    check_output("reset_write_o", write_o, 1'b0);
    check_output("reset_resp_o", resp_o, 1'b0);
    check_output("reset_address_o", address_o, 32'h0);
    check_output("reset_burst_o", burst_o, 64'h0);
    check_output("reset_line_o", line_o, '0);
    checking = 1'b1;
    rst = 1'b1;

    // plain read, resp_i held high
    run_read(32'h0000_1047, b11, b22, b33, b44, -1, 0, 1'b0, lat, first_rd, first_addr, wr_seen);
    check_output("rd_latency", 32'(lat), 32'd5);
    check_output("rd_first_read_o", first_rd, 1'b1);
    check_output("rd_address", first_addr, 32'h0000_1040);
    check_output("rd_line", line_o, rd_line);

    // write; line_o must be left alone
    run_write(32'h1234_567F, {wd, wc, wb, wa}, -1, seen, lat, first_addr);
    check_output("wr_latency", 32'(lat), 32'd5);
    check_output("wr_address", first_addr, 32'h1234_5660);
    check_output("wr_beat0", seen[0], wa);
    check_output("wr_beat1", seen[1], wb);
    check_output("wr_beat2", seen[2], wc);
    check_output("wr_beat3", seen[3], wd);
    check_output("wr_keeps_line_o", line_o, rd_line);
    @(negedge clk);
    check_output("wr_write_o_low", write_o, 1'b0);

    // read with a three-cycle stall after the first beat
    run_read(32'h8000_0020, b44, b33, b22, b11, 1, 3, 1'b0, lat, first_rd, first_addr, wr_seen);
    check_output("stall_latency", 32'(lat), 32'd8);
    check_output("stall_line", line_o, {b11, b22, b33, b44});

    // read and write together: read wins
    run_read(32'h0000_0100, b22, b44, b11, b33, -1, 0, 1'b1, lat, first_rd, first_addr, wr_seen);
    check_output("both_no_write_o", wr_seen, 1'b0);
    check_output("both_latency", 32'(lat), 32'd5);
    check_output("both_line", line_o, {b33, b11, b44, b22});

    // reset after the second write beat, then a clean read
    run_write(32'h0000_4000, {wd, wc, wb, wa}, 2, seen, lat, first_addr);
    check_output("abort_beat1", seen[1], wb);
    repeat (3) begin
      @(negedge clk);
      check_output("abort_no_resp_o", resp_o, 1'b0);
    end
    rst = 1'b1;
    run_read(32'h0000_2000, b11, b22, b33, b44, -1, 0, 1'b0, lat, first_rd, first_addr, wr_seen);
    check_output("post_reset_latency", 32'(lat), 32'd5);
    check_output("post_reset_line", line_o, rd_line);

    // back-to-back: next read starts the cycle after resp_o
    run_read(32'h0000_3000, b44, b44, b22, b22, -1, 0, 1'b0, lat, first_rd, first_addr, wr_seen);
    check_output("b2b_first_read_o", first_rd, 1'b1);
    check_output("b2b_latency", 32'(lat), 32'd5);
    check_output("b2b_line", line_o, {b22, b22, b44, b44});

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
